// File: rtl/uart_transmitter.sv
// UART 8N1 transmitter with an input byte FIFO.
// Bytes accepted on a valid/ready interface are queued and serialised LSB-first
// (start bit, 8 data bits, stop bit) with CLKS_PER_BIT clocks per bit. Queued
// bytes are sent back-to-back: the next start bit follows the stop bit directly.
module uart_transmitter #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int FC_W         = PTR_W + 1;

  localparam logic [CNT_W-1:0] CLK_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CLK_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CLK_ONE   = CNT_W'(1);
  localparam logic [FC_W-1:0]  FIFO_FULL = FC_W'(FIFO_DEPTH);
  localparam logic [FC_W-1:0]  FC_ZERO   = FC_W'(0);
  localparam logic [FC_W-1:0]  FC_ONE    = FC_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  // Frame sequencer state
  state_e            state_q,   state_d;
  logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q,   shift_d;

  // FIFO state
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q,  wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q,  rd_ptr_d;
  logic [FC_W-1:0]   count_q,   count_d;

  // Registered outputs
  logic              in_ready_q, in_ready_d;
  logic              tx_q,       tx_d;
  logic              tx_busy_q,  tx_busy_d;

  logic              push_s;
  logic              pop_s;
  logic              bit_end_s;
  logic              fifo_empty_s;

  assign push_s       = in_valid & in_ready_q;
  assign bit_end_s    = (clk_cnt_q == CLK_LAST);
  assign fifo_empty_s = (count_q == FC_ZERO);

  // Next-state logic of the frame sequencer; pops the FIFO head when a frame starts.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    pop_s     = 1'b0;
    case (state_q)
      IDLE: begin
        clk_cnt_d = CLK_ZERO;
        bit_cnt_d = 3'd0;
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          clk_cnt_d = CLK_ZERO;
          bit_cnt_d = 3'd0;
          state_d   = DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_ONE;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          clk_cnt_d = CLK_ZERO;
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_ONE;
        end
      end
      STOP: begin
        if (bit_end_s) begin
          clk_cnt_d = CLK_ZERO;
          bit_cnt_d = 3'd0;
          // Chain straight into the next frame when more bytes are waiting.
          if (!fifo_empty_s) begin
            pop_s   = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_ONE;
        end
      end
      default: begin
        state_d   = IDLE;
        clk_cnt_d = CLK_ZERO;
        bit_cnt_d = 3'd0;
      end
    endcase
  end

  // Next-state logic of the FIFO pointers and occupancy count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + FC_ONE;
      2'b01:   count_d = count_q - FC_ONE;
      default: count_d = count_q;
    endcase
  end

  // Output values for the next cycle; tx follows the current state so the
  // line changes one cycle after the sequencer does.
  always_comb begin
    tx_d       = 1'b1;
    in_ready_d = (count_d < FIFO_FULL);
    tx_busy_d  = (state_d != IDLE) || (count_d != FC_ZERO);
    case (state_q)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[bit_cnt_q];
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  // Sequencer registers; reset abandons any frame in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      clk_cnt_q <= CLK_ZERO;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  // FIFO pointer and count registers; reset empties the queue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= FC_ZERO;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // Output registers; tx goes high as soon as reset asserts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_q       <= 1'b1;
      in_ready_q <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      tx_q       <= tx_d;
      in_ready_q <= in_ready_d;
      tx_busy_q  <= tx_busy_d;
    end
  end

  assign tx         = tx_q;
  assign in_ready   = in_ready_q;
  assign tx_busy    = tx_busy_q;
  assign fifo_count = count_q;

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
UART 8N1 transmitter, the outbound counterpart of the team's UART receiver; drives the serial TX line to the PC. Bytes arrive on a valid/ready byte interface and are buffered in an internal FIFO. Frames are serialised LSB-first at BAUD_RATE from the system clock. Queued bytes go out back-to-back with no idle gap.

Parameters:
CLOCK_FREQ, 50000000, system clock frequency in Hz
BAUD_RATE, 115200, serial bit rate
FIFO_DEPTH, 16, byte FIFO entries; power of 2, >= 2
(derived) CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE (integer division); must be >= 2; default 434

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
in_data  input  8  byte to transmit
in_valid  input  1  in_data valid this cycle
in_ready  output  1  FIFO can accept; 1 = not full
tx  output  1  UART TX line, idle high
tx_busy  output  1  1 = frame in progress or FIFO non-empty
fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes queued, 0..FIFO_DEPTH

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. While reset_n=0: tx=1, in_ready=1, tx_busy=0, fifo_count=0, state=IDLE, FIFO emptied, counters cleared. A reset mid-frame aborts the frame immediately; tx returns high asynchronously. No partial frame resumes after release.
- All outputs are registered; in_ready has no combinational path from in_valid.
- Push occurs when in_valid && in_ready on a rising edge. in_ready = (fifo_count < FIFO_DEPTH). It is low when full even if a pop happens the same cycle. in_valid while in_ready=0 is ignored; no data is lost from the FIFO and no error is flagged.
- Simultaneous push and pop: fifo_count is unchanged and order is preserved. FIFO pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into the shift register, set bit_cnt=0 and clk_cnt=0, and go to START.
  - START: tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx=shift[bit_cnt] for CLKS_PER_BIT cycles per bit, bit 0 first. After bit 7 completes, go to STOP.
  - STOP: tx=1 for exactly CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go directly to START (no idle cycles). Otherwise go to IDLE.
- Frame = 10*CLKS_PER_BIT cycles exactly; a baud-period drift of zero cycles per bit is allowed.
- Latency: a byte pushed into an empty FIFO while in IDLE produces tx=0 two cycles after the accepting edge (edge k: push; edge k+1: pop; edge k+2: tx low).
- tx_busy = (state != IDLE) || (fifo_count != 0).
- The bit-period counter is $clog2(CLKS_PER_BIT) bits wide and runs 0..CLKS_PER_BIT-1, then wraps. The counter does not depend on in_valid activity.

Test Plan:
- Bench parameters unless stated: CLOCK_FREQ=1000, BAUD_RATE=100 (CLKS_PER_BIT=10), FIFO_DEPTH=16.
- Single byte: push 0xA5 at idle -> tx falls 2 cycles after accept; then 10-cycle levels 0,1,0,1,0,0,1,0,1,1; frame = 100 cycles; tx_busy drops after stop; fifo_count 1->0.
- Back-to-back: push 0x00, 0xFF, 0x55 on consecutive cycles -> three contiguous frames, 300 cycles total, no high gap beyond each 10-cycle stop bit; correct bit order.
- FIFO full: hold in_valid=1 with an incrementing pattern for 40 cycles -> fifo_count never exceeds 16; in_ready=0 while count=16; every accepted byte is transmitted exactly once, in order; non-accepted values are never emitted.
- Reset mid-frame: assert reset_n=0 during data bit 3 with 5 bytes queued -> tx=1 immediately, fifo_count=0, in_ready=1. After release, push 0x3C -> one complete, correct frame.
- Loopback: default parameters, tx wired to the team's UART receiver; send 256 random bytes -> the receiver outputs an identical sequence with no missed or extra data_valid pulses.
